retire_rat: RTL and testbench

RETIRE_RAT -- requirements
Module: retire_rat

---
 rtl/retire_rat_pkg.sv | 17 +
 rtl/free_list.sv | 79 +++++++
 rtl/retire_rat.sv | 66 ++++++
 tb/tb_retire_rat.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/retire_rat_pkg.sv
// Shared sizing parameters and the retirement commit-port type.
// The free-list capacity is whatever physical space the architectural map does not occupy.
package params;
  localparam int P_WIDTH    = 6;
  localparam int A_REG_SIZE = 32;
  localparam int FL_DEPTH   = 2**P_WIDTH - A_REG_SIZE;
endpackage

package rv32i_types;
  import params::*;

  typedef struct packed {
    logic               valid;
    logic [4:0]         rd;
    logic [P_WIDTH-1:0] pd;
  } commit_t;
endpackage

// File: rtl/free_list.sv
// Circular free list of physical registers. Head entry and occupancy are combinational from registers.
// Push and pop land on the next edge. Flush refills the list to full, and a push into a full list is dropped.
module free_list #(
  parameter int P_WIDTH    = params::P_WIDTH,
  parameter int A_REG_SIZE = params::A_REG_SIZE,
  parameter int DEPTH      = 2**P_WIDTH - A_REG_SIZE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [P_WIDTH-1:0] push_pd,
  input  logic               pop,
  input  logic               flush,
  output logic [P_WIDTH-1:0] head_pd,
  output logic               ok,
  output logic [P_WIDTH:0]   count
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = P_WIDTH + 1;

  typedef struct packed {
    logic             wrap;
    logic [IDX_W-1:0] idx;
  } ptr_t;

  ptr_t               head, tail, tail_next;
  logic [P_WIDTH-1:0] fl [DEPTH];
  logic               empty, full, push_en, pop_en;

  function automatic ptr_t inc(input ptr_t p);
    ptr_t r;
    r = p;
    if (p.idx == IDX_W'(DEPTH - 1)) begin
      r.idx  = '0;
      r.wrap = ~p.wrap;
    end else begin
      r.idx = p.idx + 1'b1;
    end
    return r;
  endfunction

  assign empty     = (head == tail);
  assign full      = (head.idx == tail.idx) && (head.wrap != tail.wrap);
  assign push_en   = push && !full;
  assign pop_en    = pop && !empty && !flush;
  assign tail_next = push_en ? inc(tail) : tail;

  assign head_pd = fl[head.idx];
  assign ok      = !empty;

  // Index arithmetic by hand so a non-power-of-two depth still counts correctly.
  always_comb begin
    if (tail.wrap == head.wrap)
      count = CW'(tail.idx) - CW'(head.idx);
    else
      count = CW'(DEPTH) + CW'(tail.idx) - CW'(head.idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++)
        fl[k] <= P_WIDTH'(A_REG_SIZE + k);
      head <= '{wrap: 1'b0, idx: '0};
      tail <= '{wrap: 1'b1, idx: '0};
    end else begin
      if (push_en)
        fl[tail.idx] <= push_pd;
      tail <= tail_next;
      // Flush reclaims every slot behind the tail, including the one just pushed.
      if (flush)
        head <= '{wrap: ~tail_next.wrap, idx: tail_next.idx};
      else if (pop_en)
        head <= inc(head);
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full))
    else $error("free_list: push into a full list");
endmodule

// File: rtl/retire_rat.sv
// Retirement RAT: committed arch->phys map and the physical free list. Map and alloc head are zero-latency.
// Updates appear after one edge. Alloc is only honoured while alloc_ok is high.
module retire_rat
  import rv32i_types::*;
#(
  parameter int P_WIDTH    = params::P_WIDTH,
  parameter int A_REG_SIZE = params::A_REG_SIZE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               commit_valid,
  input  logic [4:0]         commit_rd,
  input  logic [P_WIDTH-1:0] commit_pd,
  input  logic               flush,
  input  logic               alloc_req,
  output logic [P_WIDTH-1:0] alloc_pd,
  output logic               alloc_ok,
  output logic [P_WIDTH-1:0] RRAT [A_REG_SIZE],
  output logic [P_WIDTH:0]   free_count
);
  localparam int FL_DEPTH = 2**P_WIDTH - A_REG_SIZE;

  commit_t            cm;
  logic               commit_en;
  logic [P_WIDTH-1:0] old_pd;
  logic [P_WIDTH-1:0] rrat      [A_REG_SIZE];
  logic [P_WIDTH-1:0] rrat_next [A_REG_SIZE];

  assign cm        = '{valid: commit_valid, rd: commit_rd, pd: commit_pd};
  assign commit_en = cm.valid && (cm.rd != '0) && !rst;
  assign old_pd    = rrat[cm.rd];

  // The exported map includes this cycle's commit so a coincident flush restores it.
  always_comb begin
    rrat_next = rrat;
    if (commit_en)
      rrat_next[cm.rd] = cm.pd;
  end

  assign RRAT = rrat_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < A_REG_SIZE; i++)
        rrat[i] <= P_WIDTH'(i);
    end else if (commit_en) begin
      rrat[cm.rd] <= cm.pd;
    end
  end

  free_list #(
    .P_WIDTH    (P_WIDTH),
    .A_REG_SIZE (A_REG_SIZE),
    .DEPTH      (FL_DEPTH)
  ) u_free_list (
    .clk     (clk),
    .rst     (rst),
    .push    (commit_en),
    .push_pd (old_pd),
    .pop     (alloc_req),
    .flush   (flush),
    .head_pd (alloc_pd),
    .ok      (alloc_ok),
    .count   (free_count)
  );
endmodule

// File: tb/tb_retire_rat.sv
// Bench for retire_rat: directed scenarios then random traffic, scored against a queue-based model.
module tb_retire_rat;
  localparam int PW = 6;
  localparam int AR = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          commit_valid = 1'b0;
  logic [4:0]    commit_rd = '0;
  logic [PW-1:0] commit_pd = '0;
  logic          flush = 1'b0;
  logic          alloc_req = 1'b0;
  logic [PW-1:0] alloc_pd;
  logic          alloc_ok;
  logic [PW-1:0] rrat_o [AR];
  logic [PW:0]   free_count;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic                   ok;
    logic                   pd_chk;
    logic [PW-1:0]          pd;
    logic [PW:0]            cnt;
    logic [AR-1:0][PW-1:0]  map;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: free registers in allocation order, allocated-but-uncommitted registers in program order.
  int free_q[$];
  int infl_q[$];
  int map_m [AR];
  bit order_ok;
  bit pd_unknown;

  retire_rat #(.P_WIDTH(PW), .A_REG_SIZE(AR)) dut (
    .clk          (clk),
    .rst          (rst),
    .commit_valid (commit_valid),
    .commit_rd    (commit_rd),
    .commit_pd    (commit_pd),
    .flush        (flush),
    .alloc_req    (alloc_req),
    .alloc_pd     (alloc_pd),
    .alloc_ok     (alloc_ok),
    .RRAT         (rrat_o),
    .free_count   (free_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic model_reset();
    free_q.delete();
    infl_q.delete();
    for (int i = 0; i < AR; i++) map_m[i] = i;
    for (int k = 0; k < 2**PW - AR; k++) free_q.push_back(AR + k);
    order_ok   = 1'b1;
    pd_unknown = 1'b0;
  endtask

  function automatic exp_t cur_exp(input bit cv, input int rd, input int pd);
    exp_t e;
    e.ok     = (free_q.size() > 0);
    e.pd_chk = e.ok && !pd_unknown;
    e.pd     = '0;
    if (free_q.size() > 0) e.pd = PW'(free_q[0]);
    e.cnt    = (PW+1)'(free_q.size());
    for (int i = 0; i < AR; i++) e.map[i] = PW'(map_m[i]);
    if (cv && rd != 0) e.map[rd] = PW'(pd);
    return e;
  endfunction

  task automatic model_step(input bit a, input bit cv, input int rd, input int pd, input bit fl);
    int idx;
    if (a && free_q.size() > 0 && !fl) infl_q.push_back(free_q.pop_front());
    if (cv && rd != 0) begin
      idx = -1;
      foreach (infl_q[k]) if (infl_q[k] == pd && idx < 0) idx = k;
      if (idx > 0) order_ok = 1'b0;
      if (idx >= 0) infl_q.delete(idx);
      free_q.push_back(map_m[rd]);
      map_m[rd] = pd;
    end
    if (fl) begin
      // Discarded speculative registers come back ahead of the already-free ones.
      free_q = {infl_q, free_q};
      infl_q.delete();
      if (!order_ok) pd_unknown = 1'b1;
    end
  endtask

  task automatic cycle(input bit a, input bit cv, input int rd, input int pd, input bit fl);
    @(posedge clk);
    #1;
    alloc_req    = a;
    commit_valid = cv;
    commit_rd    = 5'(rd);
    commit_pd    = PW'(pd);
    flush        = fl;
    exp_q.push_back(cur_exp(cv, rd, pd));
    model_step(a, cv, rd, pd, fl);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #1;
    alloc_req    = 1'b1;
    commit_valid = 1'b1;
    commit_rd    = 5'd9;
    commit_pd    = PW'(50);
    flush        = 1'b1;
    rst          = 1'b1;
    model_reset();
    exp_q.push_back(cur_exp(1'b0, 0, 0));
    @(posedge clk);
    #1;
    rst          = 1'b0;
    alloc_req    = 1'b0;
    commit_valid = 1'b0;
    flush        = 1'b0;
  endtask

  exp_t e_m;
  int   bad;

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e_m = exp_q.pop_front();
        chk("alloc_ok", int'(alloc_ok), int'(e_m.ok));
        chk("free_count", int'(free_count), int'(e_m.cnt));
        if (e_m.pd_chk) chk("alloc_pd", int'(alloc_pd), int'(e_m.pd));
        bad = -1;
        for (int i = 0; i < AR; i++)
          if (rrat_o[i] !== e_m.map[i] && bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin
          failures++;
          $display("FAIL rrat[%0d]: got %0d expected %0d", bad, rrat_o[bad], e_m.map[bad]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit a, fl;
    int r;
    #1 rst = 1'b1;
    #2;
    chk("reset_alloc_ok", int'(alloc_ok), 1);
    chk("reset_alloc_pd", int'(alloc_pd), AR);
    chk("reset_free_count", int'(free_count), 32);
    chk("reset_rrat5", int'(rrat_o[5]), 5);
    chk("reset_rrat31", int'(rrat_o[31]), 31);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    cycle(0, 0, 0, 0, 0);

    // Drain the list completely, then one extra alloc against an empty list.
    repeat (33) cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 5, 40, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 33, 0);
    cycle(0, 0, 0, 0, 0);
    mid_reset();
    cycle(0, 0, 0, 0, 0);

    // Flush with a coincident commit and alloc.
    repeat (10) cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 3, 34, 1);
    cycle(1, 0, 0, 0, 0);
    mid_reset();
    cycle(0, 0, 0, 0, 0);

    // Push and pop together with one free entry left, then watch the freed register wrap round.
    repeat (31) cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 7, 32, 0);
    cycle(0, 0, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      a  = ($urandom_range(0, 99) < 55);
      fl = ($urandom_range(0, 99) < 3);
      r  = $urandom_range(0, 99);
      if (n % 700 == 699)
        mid_reset();
      else if (r < 45 && infl_q.size() > 0)
        cycle(a, 1, $urandom_range(1, 31), infl_q[0], fl);
      else if (r < 50)
        cycle(a, 1, 0, $urandom_range(0, 63), fl);
      else
        cycle(a, 0, 0, 0, fl);
    end
    cycle(0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
